// File: rtl/m_pkg.sv
// Shared types for the match pipeline: input word format and lane helpers.
package m_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [BYTES_PER_WORD-1:0][7:0] data_t;
    typedef logic [1:0] byte_idx_t;

    typedef struct packed {
        logic      sop;
        logic      eop;
        byte_idx_t length;
        data_t     data;
    } in_t;

    // Bit i set when lane i holds a valid byte (length counts from zero).
    function automatic logic [BYTES_PER_WORD-1:0] len_to_unary_mask(input byte_idx_t len);
        logic [BYTES_PER_WORD-1:0] mask;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            mask[i] = (i <= int'(len));
        end
        return mask;
    endfunction

endpackage

// File: rtl/m_in_packer_oreg.sv
// Single-entry output register with vld/accept handshake; a load always wins
// over a drain, so a new word can replace an accepted one with no bubble.
module m_in_packer_oreg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic arst_n,
    input  logic load,
    input  T     load_data,
    input  logic accept,
    output logic vld,
    output T     data
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            data <= load_data;
        end else if (accept) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/m_in_packer.sv
// Byte-serial to m_pkg::in_t word packer with one parked word of slack.
// Build option: M_IN_PACKER_ZERO_PAD_EN zeroes lanes above length.
module m_in_packer
    import m_pkg::*;
(
    input  logic       clk,
    input  logic       arst_n,
    input  logic       in_vld,
    input  logic [7:0] in_byte,
    input  logic       in_last,
    output logic       in_accept,
    output logic       out_vld,
    output in_t        out,
    input  logic       out_accept
);

    logic [2:0][7:0] acc_data;
    byte_idx_t       acc_cnt;
    logic            acc_sop;
    logic            held;
    logic [7:0]      hold_byte;
    logic            hold_eop;

    logic            oreg_free;
    logic            in_fire;
    logic            completes;
    logic            load;
    logic [7:0]      word_byte;
    logic            word_eop;
    in_t             word;

    // Backpressure comes only from the parked-word flag, never from out_accept.
    assign in_accept = !held;
    assign oreg_free = !out_vld || out_accept;
    assign in_fire   = in_vld && in_accept;
    assign completes = in_fire && (in_last || acc_cnt == 2'd3);
    assign word_byte = held ? hold_byte : in_byte;
    assign word_eop  = held ? hold_eop  : in_last;
    assign load      = (held || completes) && oreg_free;

`ifdef M_IN_PACKER_ZERO_PAD_EN
    logic [BYTES_PER_WORD-1:0] lane_mask;
`endif

    always_comb begin
        word              = '0;
        word.sop          = acc_sop;
        word.eop          = word_eop;
        word.length       = acc_cnt;
        word.data[2:0]    = acc_data;
        word.data[3]      = word_byte;
        word.data[acc_cnt] = word_byte;
`ifdef M_IN_PACKER_ZERO_PAD_EN
        lane_mask = len_to_unary_mask(acc_cnt);
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (!lane_mask[i]) begin
                word.data[i] = 8'h00;
            end
        end
`endif
    end

    // The completing byte is parked in hold_byte rather than the accumulator,
    // so a full 4-byte word can wait while acc_cnt still indexes its last lane.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc_data  <= '0;
            acc_cnt   <= '0;
            acc_sop   <= 1'b1;
            held      <= 1'b0;
            hold_byte <= 8'h00;
            hold_eop  <= 1'b0;
        end else if (held) begin
            if (oreg_free) begin
                held    <= 1'b0;
                acc_cnt <= '0;
                acc_sop <= hold_eop;
            end
        end else if (completes) begin
            if (oreg_free) begin
                acc_cnt <= '0;
                acc_sop <= in_last;
            end else begin
                held      <= 1'b1;
                hold_byte <= in_byte;
                hold_eop  <= in_last;
            end
        end else if (in_fire) begin
            case (acc_cnt)
                2'd0:    acc_data[0] <= in_byte;
                2'd1:    acc_data[1] <= in_byte;
                default: acc_data[2] <= in_byte;
            endcase
            acc_cnt <= acc_cnt + 2'd1;
        end
    end

    m_in_packer_oreg #(
        .T (in_t)
    ) u_oreg (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (load),
        .load_data (word),
        .accept    (out_accept),
        .vld       (out_vld),
        .data      (out)
    );

endmodule

// File: tb/tb_m_in_packer.sv
// Directed and randomised-backpressure bench for m_in_packer.
module tb_m_in_packer;
    import m_pkg::*;

    logic       clk;
    logic       arst_n;
    logic       in_vld;
    logic [7:0] in_byte;
    logic       in_last;
    logic       in_accept;
    logic       out_vld;
    in_t        out_w;
    logic       out_accept;

    int  vec_cnt;
    int  err_cnt;
    int  stall_cnt;
    int  chk_idx;
    int  out_mode;
    logic model_sop;
    in_t rx_q[$];
    in_t exp_q[$];

    m_in_packer dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_vld     (in_vld),
        .in_byte    (in_byte),
        .in_last    (in_last),
        .in_accept  (in_accept),
        .out_vld    (out_vld),
        .out        (out_w),
        .out_accept (out_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // out_accept policy: 0 = always, 1 = never, 2 = coin flip each cycle
    initial begin
        out_accept = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (out_mode)
                0:       out_accept = 1'b1;
                1:       out_accept = 1'b0;
                default: out_accept = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Records transfers that will happen on the coming rising edge.
    initial begin
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (out_vld && out_accept) rx_q.push_back(out_w);
                if (in_vld && !in_accept) stall_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic in_t mkWord(input logic sop, input logic eop, input logic [1:0] len,
                                   input logic [31:0] d);
        in_t w;
        w.sop    = sop;
        w.eop    = eop;
        w.length = len;
        w.data   = d;
        return w;
    endfunction

    function automatic in_t maskWord(input in_t w);
        in_t m;
        m = w;
`ifndef M_IN_PACKER_ZERO_PAD_EN
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i > int'(w.length)) m.data[i] = 8'h00;
        end
`endif
        return m;
    endfunction

    task automatic checkWord(input string tag, input in_t got, input in_t exp);
        checkOutput(tag, {28'd0, maskWord(got)}, {28'd0, maskWord(exp)});
    endtask

    // Entered and left at posedge+1; presents one byte until it is accepted.
    task automatic applyStimulus(input logic [7:0] b, input logic last);
        int n;
        in_vld  = 1'b1;
        in_byte = b;
        in_last = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_accept && n < 200);
        if (!in_accept) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            in_vld = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drainAndCompare(input string tag);
        int n;
        n = 0;
        while (rx_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checkOutput({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            checkWord($sformatf("%s_w%0d", tag, i - chk_idx), rx_q[i], exp_q[i]);
        end
        chk_idx = exp_q.size();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   base;
        int   plen;
        int   cnt;
        logic [7:0] b;
        logic last;
        data_t cur;

        vec_cnt   = 0;
        err_cnt   = 0;
        chk_idx   = 0;
        out_mode  = 0;
        model_sop = 1'b1;
        in_vld    = 1'b0;
        in_byte   = 8'h00;
        in_last   = 1'b0;
        arst_n    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_out_vld", 64'(out_vld), 64'd0);
        checkOutput("rst_out", {28'd0, out_w}, 64'd0);
        checkOutput("rst_in_accept", 64'(in_accept), 64'd1);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // single-byte packet, visible the cycle after acceptance
        exp_q.push_back(mkWord(1'b1, 1'b1, 2'd0, 32'h0000_00AA));
        applyStimulus(8'hAA, 1'b1);
        checkOutput("lat_out_vld", 64'(out_vld), 64'd1);
        checkWord("lat_word", out_w, mkWord(1'b1, 1'b1, 2'd0, 32'h0000_00AA));
        drainAndCompare("one_byte");

        base = stall_cnt;
        exp_q.push_back(mkWord(1'b1, 1'b1, 2'd3, 32'h0403_0201));
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), i == 4);
        checkOutput("four_no_stall", 64'(stall_cnt - base), 64'd0);
        drainAndCompare("four_byte");

        exp_q.push_back(mkWord(1'b1, 1'b0, 2'd3, 32'h1312_1110));
        exp_q.push_back(mkWord(1'b0, 1'b1, 2'd1, 32'h0000_1514));
        for (int i = 0; i < 6; i++) applyStimulus(8'h10 + 8'(i), i == 5);
        drainAndCompare("six_byte");

        // backpressure: second word parks, input stalls, output holds still
        out_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mkWord(1'b1, 1'b0, 2'd3, 32'h2322_2120));
        exp_q.push_back(mkWord(1'b0, 1'b1, 2'd3, 32'h2726_2524));
        for (int i = 0; i < 8; i++) applyStimulus(8'h20 + 8'(i), i == 7);
        checkOutput("held_in_accept", 64'(in_accept), 64'd0);
        checkWord("held_out0", out_w, mkWord(1'b1, 1'b0, 2'd3, 32'h2322_2120));
        repeat (3) @(negedge clk);
        checkOutput("held_out_vld", 64'(out_vld), 64'd1);
        checkWord("held_out1", out_w, mkWord(1'b1, 1'b0, 2'd3, 32'h2322_2120));
        @(posedge clk);
        #1;
        out_mode = 0;
        #2;
        checkOutput("no_comb_path", 64'(in_accept), 64'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("handoff_vld", 64'(out_vld), 64'd1);
        checkWord("handoff_word", out_w, mkWord(1'b0, 1'b1, 2'd3, 32'h2726_2524));
        drainAndCompare("hold");

        // reset mid-packet drops the partial word
        @(posedge clk);
        #1;
        applyStimulus(8'h66, 1'b0);
        applyStimulus(8'h77, 1'b0);
        doReset();
        checkOutput("mid_rst_in_accept", 64'(in_accept), 64'd1);
        exp_q.push_back(mkWord(1'b1, 1'b1, 2'd0, 32'h0000_0055));
        applyStimulus(8'h55, 1'b1);
        drainAndCompare("mid_reset");

        out_mode  = 2;
        model_sop = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            plen = $urandom_range(1, 12);
            cnt  = 0;
            cur  = '0;
            for (int i = 0; i < plen; i++) begin
                b    = 8'($urandom_range(0, 255));
                last = (i == plen - 1);
                cur[cnt] = b;
                if (last || cnt == 3) begin
                    exp_q.push_back(mkWord(model_sop, last, 2'(cnt), cur));
                    model_sop = last;
                    cnt = 0;
                    cur = '0;
                end else begin
                    cnt++;
                end
                applyStimulus(b, last);
            end
        end
        out_mode = 0;
        drainAndCompare("random");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
